// File: rtl/aibnd_clkmux_selctl.sv
// Select sequencer for the redundancy 2:1 clock mux: gates the downstream clock,
// flips the select, waits for the mux to settle, then ungates.
module aibnd_clkmux_selctl #(
  parameter int GATE_CYC   = 4,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 4,
  parameter bit RST_SEL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic req_sel,
  input  logic sel_lock,
  output logic mux_sel,
  output logic clk_en,
  output logic busy,
  output logic switch_done
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_GATE, ST_SETTLE} state_e;

  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mux_sel_q, mux_sel_d;
  logic             clk_en_q, clk_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_zero;
  logic             start;

  assign cnt_zero = (cnt_q == '0);
  // sel_lock only holds off a new sequence; it never interrupts a running one.
  assign start    = (state_q == ST_IDLE) && (req_sel != mux_sel_q) && !sel_lock;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= SETTLE_LD;
      mux_sel_q <= RST_SEL;
      clk_en_q  <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mux_sel_q <= mux_sel_d;
      clk_en_q  <= clk_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   if (cnt_zero) state_d = ST_IDLE;
      ST_IDLE:   if (start)    state_d = ST_GATE;
      ST_GATE:   if (cnt_zero) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_zero) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q - CNT_W'(1);
    mux_sel_d = mux_sel_q;
    clk_en_d  = clk_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (cnt_zero) begin
          clk_en_d = 1'b1;
          busy_d   = 1'b0;
        end
      end
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (start) begin
          clk_en_d = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = GATE_LD;
        end
      end
      ST_GATE: begin
        // req_sel is sampled only here; a matching value means a no-op switch.
        if (cnt_zero) begin
          mux_sel_d = req_sel;
          cnt_d     = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          clk_en_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
    endcase
  end

  assign mux_sel     = mux_sel_q;
  assign clk_en      = clk_en_q;
  assign busy        = busy_q;
  assign switch_done = done_q;

`ifndef SYNTHESIS
  // The select may only move while the clock is gated on both sides of the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ((mux_sel_d == mux_sel_q) || (!clk_en_q && !clk_en_d));
    end
  end
`endif

endmodule

// File: tb/tb_aibnd_clkmux_selctl.sv
// Bench for aibnd_clkmux_selctl: directed vector table, hand-written corner
// sequences, and a random run against an elapsed-time reference model.
module tb_aibnd_clkmux_selctl;

  localparam int GATE_CYC   = 4;
  localparam int SETTLE_CYC = 4;
  localparam int CNT_W      = 4;
  localparam bit RST_SEL    = 1'b0;

  localparam int M_START  = 0;
  localparam int M_IDLE   = 1;
  localparam int M_SWITCH = 2;

  logic clk = 1'b0;
  logic reset;
  logic req_sel;
  logic sel_lock;
  logic mux_sel;
  logic clk_en;
  logic busy;
  logic switch_done;

  int n_checks = 0;
  int n_errors = 0;

  aibnd_clkmux_selctl #(
    .GATE_CYC  (GATE_CYC),
    .SETTLE_CYC(SETTLE_CYC),
    .CNT_W     (CNT_W),
    .RST_SEL   (RST_SEL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_sel    (req_sel),
    .sel_lock   (sel_lock),
    .mux_sel    (mux_sel),
    .clk_en     (clk_en),
    .busy       (busy),
    .switch_done(switch_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: counts edges elapsed since the phase began
  typedef struct {
    int   mode;
    int   t;
    logic sel;
    logic en;
    logic busy;
    logic done;
  } mstate_t;

  mstate_t    m;
  logic [3:0] exp_q[$];

  function automatic mstate_t model_reset();
    mstate_t r;
    r.mode = M_START; r.t = 0; r.sel = RST_SEL; r.en = 1'b0; r.busy = 1'b1; r.done = 1'b0;
    return r;
  endfunction

  function automatic mstate_t model_step(mstate_t s, logic req, logic lock);
    mstate_t n;
    n = s;
    n.done = 1'b0;
    n.t = s.t + 1;
    case (s.mode)
      M_START: if (n.t == SETTLE_CYC) begin
        n.en = 1'b1; n.busy = 1'b0; n.mode = M_IDLE;
      end
      M_IDLE: if (req != s.sel && !lock) begin
        n.mode = M_SWITCH; n.t = 0; n.en = 1'b0; n.busy = 1'b1;
      end
      default: begin
        if (n.t == GATE_CYC) n.sel = req;
        if (n.t == GATE_CYC + SETTLE_CYC) begin
          n.en = 1'b1; n.busy = 1'b0; n.done = 1'b1; n.mode = M_IDLE;
        end
      end
    endcase
    return n;
  endfunction

  function automatic logic [3:0] pack(mstate_t s);
    return {s.sel, s.en, s.busy, s.done};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m <= model_reset();
      exp_q.delete();
    end else begin
      m <= model_step(m, req_sel, sel_lock);
      exp_q.push_back(pack(model_step(m, req_sel, sel_lock)));
    end
  end

  // scoreboard + glitch-safety check on the select
  logic p_sel, p_en, inv_valid = 1'b0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) chk("model", {mux_sel, clk_en, busy, switch_done}, exp_q.pop_front());
    if (inv_valid && !reset && (mux_sel !== p_sel))
      chk("sel_change_while_enabled", {2'b00, p_en, clk_en}, 4'b0000);
    p_sel     <= mux_sel;
    p_en      <= clk_en;
    inv_valid <= !reset;
  end

  // driver tasks
  task automatic step(input logic r, input logic l);
    req_sel  = r;
    sel_lock = l;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       req;
    logic       lock;
    logic [3:0] exp;   // {mux_sel, clk_en, busy, switch_done}
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input logic r, input logic l, input logic [3:0] e);
    vec_t v;
    v.req = r; v.lock = l; v.exp = e;
    vt.push_back(v);
  endtask

  initial begin
    // startup settle after reset exit
    repeat (3) add_vec(1'b0, 1'b0, 4'b0010);
    repeat (2) add_vec(1'b0, 1'b0, 4'b0100);
    // basic 0->1 switch
    repeat (4) add_vec(1'b1, 1'b0, 4'b0010);
    repeat (4) add_vec(1'b1, 1'b0, 4'b1010);
    add_vec(1'b1, 1'b0, 4'b1101);
    add_vec(1'b1, 1'b0, 4'b1100);
    // aborted switch: request withdrawn two cycles in
    repeat (2) add_vec(1'b0, 1'b0, 4'b1010);
    repeat (6) add_vec(1'b1, 1'b0, 4'b1010);
    add_vec(1'b1, 1'b0, 4'b1101);
    add_vec(1'b1, 1'b0, 4'b1100);
    // locked with toggling request
    for (int i = 0; i < 20; i++) add_vec(i[0], 1'b1, 4'b1100);
    // unlock with pending mismatch, relock mid-sequence
    repeat (2) add_vec(1'b0, 1'b0, 4'b1010);
    repeat (2) add_vec(1'b0, 1'b1, 4'b1010);
    repeat (4) add_vec(1'b0, 1'b1, 4'b0010);
    add_vec(1'b0, 1'b1, 4'b0101);
    repeat (2) add_vec(1'b0, 1'b0, 4'b0100);

    reset    = 1'b0;
    req_sel  = 1'b0;
    sel_lock = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_state", {mux_sel, clk_en, busy, switch_done}, 4'b0010);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].req, vt[i].lock);
      chk($sformatf("vec%0d", i), {mux_sel, clk_en, busy, switch_done}, vt[i].exp);
    end

    // request reversed during SETTLE
    repeat (5) step(1'b1, 1'b0);
    chk("settle_sel_e4", {3'b000, mux_sel}, 4'b0001);
    repeat (4) step(1'b0, 1'b0);
    chk("settle_first_done", {mux_sel, clk_en, busy, switch_done}, 4'b1101);
    step(1'b0, 1'b0);
    chk("settle_second_start", {mux_sel, clk_en, busy, switch_done}, 4'b1010);
    repeat (4) step(1'b0, 1'b0);
    chk("settle_second_sel", {mux_sel, clk_en, busy, switch_done}, 4'b0010);
    repeat (3) step(1'b0, 1'b0);
    chk("settle_second_gated", {2'b00, clk_en, busy}, 4'b0001);
    step(1'b0, 1'b0);
    chk("settle_second_done", {mux_sel, clk_en, busy, switch_done}, 4'b0101);

    // reset in the middle of GATE
    repeat (3) step(1'b1, 1'b0);
    #1 reset = 1'b1;
    #1 chk("reset_mid_gate", {mux_sel, clk_en, busy, switch_done}, 4'b0010);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    chk("rst_resettle", {mux_sel, clk_en, busy, switch_done}, 4'b0010);
    step(1'b1, 1'b0);
    chk("rst_idle", {mux_sel, clk_en, busy, switch_done}, 4'b0100);
    step(1'b1, 1'b0);
    chk("rst_restart", {mux_sel, clk_en, busy, switch_done}, 4'b0010);
    repeat (4) step(1'b1, 1'b0);
    chk("rst_restart_sel", {mux_sel, clk_en, busy, switch_done}, 4'b1010);
    repeat (5) step(1'b1, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 9) req_sel = ~req_sel;
      sel_lock = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 149) == 0) begin
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
